// File: rtl/lsu_pkg.sv
// lsu_pkg: shared op encodings, FSM states and access legality check for mem_access_unit
package lsu_pkg;

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    // Unsigned sub-word ops only make sense for loads; halves need even
    // addresses and words need word-aligned addresses.
    function automatic logic access_ok(input logic is_store, input logic [2:0] op, input logic [1:0] a);
        return (op == OP_B) || (op == OP_BU && !is_store) ||
               (op == OP_H && !a[0]) || (op == OP_HU && !is_store && !a[0]) ||
               (op == OP_W && a == 2'b00);
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// lsu_lane: combinational byte/half lane extraction with extension for loads and lane merge for stores
//   word       : 32-bit word read from memory
//   addr       : byte offset within the word (little-endian lanes)
//   op         : access size/sign encoding
//   store_data : right-aligned store data (only the low half is ever merged)
//   load_data  : extracted and sign/zero-extended load value
//   merged     : word with the addressed byte/half replaced by store_data
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  logic [2:0]  op,
    input  logic [15:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [4:0]  sh;
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        sh        = {addr, 3'b000};
        b         = 8'(word >> sh);
        h         = addr[1] ? word[31:16] : word[15:0];
        load_data = op == OP_B  ? {{24{b[7]}}, b} :
                    op == OP_BU ? {24'h0, b} :
                    op == OP_H  ? {{16{h[15]}}, h} :
                    op == OP_HU ? {16'h0, h} : word;
        merged    = op == OP_H ? (addr[1] ? {store_data, word[15:0]} : {word[31:16], store_data}) :
                    (word & ~(32'hFF << sh)) | ({24'h0, store_data[7:0]} << sh);
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store alignment stage converting B/H/W accesses into word-only memory accesses
//   clk, reset   : clock, synchronous active-high reset
//   req          : MEM-stage access request (inputs held while stall=1)
//   isStore, op  : direction and size/sign of the access
//   address      : byte address; storeData: right-aligned store data
//   stall        : combinational pipeline hold during the read half of a sub-word store
//   loadData     : registered extended load result, qualified by loadValid
//   fault        : registered pulse for misaligned access or illegal op
//   memAddress, memDataWrite, memWrite, memRead, memDataRead : word-wide data memory port
module mem_access_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              isStore,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       storeData,
    output logic              stall,
    output logic [31:0]       loadData,
    output logic              loadValid,
    output logic              fault,
    output logic [ADDR_W-1:0] memAddress,
    output logic [31:0]       memDataWrite,
    output logic              memWrite,
    output logic              memRead,
    input  logic [31:0]       memDataRead
);

    state_t            state;
    logic [31:0]       buffer;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0] word_addr;
    logic [31:0]       lane_load;
    logic [31:0]       lane_merged;
    logic              idle;
    logic              ok;
    logic              accept;

    lsu_lane u_lane (
        .word       (memDataRead),
        .addr       (address[1:0]),
        .op         (op),
        .store_data (storeData[15:0]),
        .load_data  (lane_load),
        .merged     (lane_merged)
    );

    // Reset gates the enables so nothing reaches memory while reset is held.
    always_comb begin
        idle         = state == S_IDLE;
        ok           = access_ok(isStore, op, address[1:0]);
        word_addr    = {address[ADDR_W-1:2], 2'b00};
        accept       = idle && req && ok && !reset;
        stall        = idle && req && ok && isStore && op != OP_W;
        memRead      = accept && (!isStore || op != OP_W);
        memWrite     = !reset && (!idle || (accept && isStore && op == OP_W));
        memAddress   = idle ? word_addr : waddr;
        memDataWrite = idle ? storeData : buffer;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            loadData  <= '0;
            loadValid <= 1'b0;
            fault     <= 1'b0;
            buffer    <= '0;
            waddr     <= '0;
        end else begin
            loadValid <= accept && !isStore;
            fault     <= idle && req && !ok;
            if (accept && !isStore) loadData <= lane_load;
            if (stall) begin
                buffer <= lane_merged;
                waddr  <= word_addr;
            end
            state <= stall ? S_WRITE : S_IDLE;
        end
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store alignment stage that sits directly upstream of the data memory (`memdados`) in the MIPS datapath. It converts byte, halfword and word loads/stores from the MEM stage into word-only memory accesses, and performs sub-word stores as a two-cycle read-modify-write. It sign- or zero-extends load results into a registered output for write-back. Misaligned accesses and illegal opcodes are flagged as faults and never reach memory.

## Interface
Parameters:
- `ADDR_W`, 32: address width.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  1  access request from the MEM stage; inputs held stable while `stall`=1.
- `isStore`  in  1  1 = store, 0 = load.
- `op`  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU; other codes are illegal; BU/HU are illegal for stores.
- `address`  in  32  byte address.
- `storeData`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `stall`  out  1  combinational; holds the pipeline.
- `loadData`  out  32  registered, extended load result.
- `loadValid`  out  1  registered one-cycle pulse qualifying `loadData`.
- `fault`  out  1  registered one-cycle pulse: misaligned access or illegal op.
- `memAddress`  out  32  word address to memory; `address` with [1:0] forced to 00.
- `memDataWrite`  out  32  word to write.
- `memWrite`  out  1  memory write enable.
- `memRead`  out  1  memory read enable.
- `memDataRead`  in  32  combinational read data from memory.

## Operation
- Byte lanes are little-endian: byte k = bits [8k+7:8k] with k = `address[1:0]`; half lane = `address[1]`.
- Alignment: H/HU need `address[0]`=0; W needs `address[1:0]`=00. A violation or illegal op in IDLE with `req` raises `fault` the next cycle. There is no memory access, `stall` stays 0, and `loadValid` stays 0.
- FSM states:
  - IDLE: accepts requests.
  - WRITE: drives the merged sub-word store.
- Load (IDLE, `req`, legal):
  - `memRead`=1 for that cycle.
  - The lane is extracted from `memDataRead`. B/H are sign-extended; BU/HU are zero-extended.
  - The result is registered into `loadData`. `stall`=0.
- Word store (IDLE, `req`, legal): `memWrite`=1 and `memDataWrite`=`storeData` in the same cycle; `stall`=0.
- Sub-word store (SB/SH, legal):
  - Cycle A (IDLE): `memRead`=1 and `stall`=1. Latch into a buffer register `memDataRead` with the new lane merged from `storeData`, and latch the word address. Go to WRITE.
  - Cycle B (WRITE): `memWrite`=1, `memDataWrite`=buffer, `memAddress`=latched address, `stall`=0. Return to IDLE. Inputs are ignored in this state; the upstream request completes at the end of B.
- `memRead`/`memWrite` are never both 1. Both are 0 when `req`=0 in IDLE, and both are 0 while `reset`=1.
- Reset values: state IDLE, `loadData`=0, `loadValid`=0, `fault`=0, buffer=0.
- Reset in cycle A or B: return to IDLE next edge, no `memWrite` issued, memory unchanged.

## Timing
- Load: request in cycle n; `loadData`/`loadValid` valid in cycle n+1.
- Word store: memory updated at the end of the request cycle. A load to the same word in the next cycle returns the new value.
- Sub-word store: 2 cycles, 1 stall cycle; memory updated at the end of cycle B. A back-to-back request is accepted in the cycle after B.
- `fault`: asserted in cycle n+1 for one cycle.
- `stall` is purely combinational from state, `req`, `isStore`, `op` and `address`.

## Structure
- Package `lsu_pkg`:
  - op encodings (`OP_B`, `OP_H`, `OP_W`, `OP_BU`, `OP_HU`);
  - FSM state enum (`S_IDLE`, `S_WRITE`);
  - a function checking alignment/legality.
- Sub-module `lsu_lane` (combinational):
  - extract/extend for loads;
  - lane merge for stores.
  - Inputs: word, `address[1:0]`, `op`, `storeData`.
  - Instantiated once; the top holds the FSM and registers.

## Test plan
- Word 0x10 = 0x8899AABB. Loads from that word:
  - LB 0x13 → `loadData`=0xFFFFFF88, `loadValid`=1 next cycle.
  - LBU 0x13 → 0x00000088.
  - LH 0x12 → 0xFFFF8899.
  - LHU 0x10 → 0x0000AABB.
- SB 0x11, `storeData`=0x000000CC:
  - `stall`=1 for one cycle, then `memWrite`=1 with 0x8899CCBB.
  - A following LW 0x10 → 0x8899CCBB.
- SH 0x12, `storeData`=0x00001234 → written 0x1234AABB.
- SW 0x10 = 0xDEADBEEF, then LW 0x10 next cycle → 0xDEADBEEF. No stall cycles.
- Faults: LW 0x06, SH 0x11 and op 011 → each gives a one-cycle `fault` pulse, with `memRead`=`memWrite`=0 and `loadValid`=0.
- Reset mid-store: assert `reset` during cycle A of SB 0x11 → no `memWrite` ever, word still 0x8899AABB, all outputs 0, FSM in IDLE.
